// File: rtl/chain_mixer_dose_ctrl.sv
// Dose/mix sequencer for a chain of mixer stages: sample inlet, per-stage reagent dose + mix hold, drain.
// Optional post-drain flush of every reagent inlet is compiled in with CHAIN_MIXER_FLUSH_EN.
module chain_mixer_dose_ctrl #(
  parameter int N_STAGES = 8,
  parameter int CNT_W    = 8,
  localparam int STG_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    dose_cycles,
  input  logic [CNT_W-1:0]    mix_cycles,
  output logic                sample_valve,
  output logic [N_STAGES-1:0] reagent_valve,
  output logic                outlet_valve,
  output logic [STG_W-1:0]    stage,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DOSE  = 3'd2,
    MIX   = 3'd3,
    DRAIN = 3'd4,
`ifdef CHAIN_MIXER_FLUSH_EN
    FLUSH = 3'd5,
`endif
    DONE  = 3'd6
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   dose_lat;
  logic [CNT_W-1:0]   mix_lat;
  logic [CNT_W-1:0]   dose_eff;
  logic [CNT_W-1:0]   mix_eff;
  logic               cnt_last;
  logic               stage_last;

  // A programmed duration of zero still holds each timed state for one cycle.
  function automatic logic [CNT_W-1:0] min1(input logic [CNT_W-1:0] v);
    min1 = (v == '0) ? CNT_W'(1) : v;
  endfunction

  function automatic logic [N_STAGES-1:0] onehot(input logic [STG_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign dose_eff   = min1(dose_lat);
  assign mix_eff    = min1(mix_lat);
  assign cnt_last   = (cnt == CNT_W'(1));
  assign stage_last = (stage == STG_W'(N_STAGES - 1));
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      dose_lat      <= '0;
      mix_lat       <= '0;
      stage         <= '0;
      sample_valve  <= 1'b0;
      reagent_valve <= '0;
      outlet_valve  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else if (abort) begin
      state         <= IDLE;
      cnt           <= '0;
      stage         <= '0;
      sample_valve  <= 1'b0;
      reagent_valve <= '0;
      outlet_valve  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          stage <= '0;
          if (start) begin
            dose_lat     <= dose_cycles;
            mix_lat      <= mix_cycles;
            cnt          <= min1(dose_cycles);
            sample_valve <= 1'b1;
            busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (cnt_last) begin
            sample_valve  <= 1'b0;
            reagent_valve <= onehot('0);
            cnt           <= dose_eff;
            state         <= DOSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DOSE: begin
          if (cnt_last) begin
            reagent_valve <= '0;
            cnt           <= mix_eff;
            state         <= MIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        MIX: begin
          if (cnt_last) begin
            cnt <= dose_eff;
            if (stage_last) begin
              outlet_valve <= 1'b1;
              state        <= DRAIN;
            end else begin
              stage         <= stage + STG_W'(1);
              reagent_valve <= onehot(stage + STG_W'(1));
              state         <= DOSE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DRAIN: begin
          if (cnt_last) begin
`ifdef CHAIN_MIXER_FLUSH_EN
            // Outlet stays open while every reagent inlet is flushed.
            reagent_valve <= '1;
            cnt           <= dose_eff;
            state         <= FLUSH;
`else
            outlet_valve <= 1'b0;
            done         <= 1'b1;
            cnt          <= '0;
            state        <= DONE;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef CHAIN_MIXER_FLUSH_EN
        FLUSH: begin
          if (cnt_last) begin
            reagent_valve <= '0;
            outlet_valve  <= 1'b0;
            done          <= 1'b1;
            cnt           <= '0;
            state         <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          stage <= '0;
          state <= IDLE;
        end
        default: begin
          state         <= IDLE;
          cnt           <= '0;
          stage         <= '0;
          sample_valve  <= 1'b0;
          reagent_valve <= '0;
          outlet_valve  <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chain_mixer_dose_ctrl.sv
// Directed bench for chain_mixer_dose_ctrl: full runs, zero durations, abort, mid-run restart/reset.
module tb_chain_mixer_dose_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] dose_cycles;
  logic [7:0] mix_cycles;
  logic       sample_valve;
  logic [7:0] reagent_valve;
  logic       outlet_valve;
  logic [2:0] stage;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chain_mixer_dose_ctrl #(.N_STAGES(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dose_cycles(dose_cycles), .mix_cycles(mix_cycles),
    .sample_valve(sample_valve), .reagent_valve(reagent_valve),
    .outlet_valve(outlet_valve), .stage(stage), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs at cycle c (cycle k = state after edge k-1 of the run; c<1 means idle).
  task automatic check_cycle(input int c, input int d_raw, input int m_raw);
    int d, m, t, i, r;
    logic       e_sv, e_ov, e_dn, e_bs;
    logic [7:0] e_rv;
    logic [2:0] e_st;
    d = (d_raw == 0) ? 1 : d_raw;
    m = (m_raw == 0) ? 1 : m_raw;
    e_sv = 0; e_ov = 0; e_dn = 0; e_bs = 0; e_rv = 8'h00; e_st = 3'd0;
    if (c >= 1 && c <= d) begin
      e_sv = 1; e_bs = 1;
    end else if (c > d) begin
      t = c - 1 - d;
      if (t < 8 * (d + m)) begin
        i = t / (d + m);
        r = t % (d + m);
        e_bs = 1;
        e_st = 3'(i);
        if (r < d) e_rv = 8'(1 << i);
      end else begin
        t = t - 8 * (d + m);
        if (t < d) begin
          e_ov = 1; e_bs = 1; e_st = 3'd7;
        end else begin
          t = t - d;
`ifdef CHAIN_MIXER_FLUSH_EN
          if (t < d) begin
            e_rv = 8'hFF; e_ov = 1; e_bs = 1; e_st = 3'd7;
            t = -1;
          end else begin
            t = t - d;
          end
`endif
          if (t == 0) begin
            e_dn = 1; e_bs = 1; e_st = 3'd7;
          end
        end
      end
    end
    chk("sample_valve",  c, 32'(sample_valve),  32'(e_sv));
    chk("reagent_valve", c, 32'(reagent_valve), 32'(e_rv));
    chk("outlet_valve",  c, 32'(outlet_valve),  32'(e_ov));
    chk("done",          c, 32'(done),          32'(e_dn));
    chk("busy",          c, 32'(busy),          32'(e_bs));
    chk("stage",         c, 32'(stage),         32'(e_st));
  endtask

  function automatic int done_cycle(input int d_raw, input int m_raw);
    int d, m;
    d = (d_raw == 0) ? 1 : d_raw;
    m = (m_raw == 0) ? 1 : m_raw;
`ifdef CHAIN_MIXER_FLUSH_EN
    return 1 + d + 8 * (d + m) + d + d;
`else
    return 1 + d + 8 * (d + m) + d;
`endif
  endfunction

  // Pulse start, then check cycles 1..last_c; at poke_c re-pulse start with a different dose.
  task automatic run_seq(input int d, input int m, input int last_c, input int poke_c);
    start = 1; dose_cycles = 8'(d); mix_cycles = 8'(m);
    tick;
    start = 0;
    for (int c = 1; c <= last_c; c++) begin
      check_cycle(c, d, m);
      if (c == poke_c) begin
        start = 1; dose_cycles = 8'(d + 5); mix_cycles = 8'(m + 4);
      end else begin
        start = 0;
      end
      tick;
    end
    start = 0;
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; dose_cycles = 8'd0; mix_cycles = 8'd0;
    #12;
    check_cycle(0, 2, 3);
    chk("rst_state", 0, 32'(state_dbg), 32'd0);
    @(negedge clk) rst_n = 1;
    tick;
    check_cycle(0, 2, 3);

    // Full run d=2 m=3 with a re-pulsed start and changed durations at cycle 20.
    run_seq(2, 3, done_cycle(2, 3) + 2, 20);

    // Zero durations: every timed state lasts one cycle.
    run_seq(0, 0, done_cycle(0, 0) + 2, -1);

    // Abort beats start in idle.
    abort = 1; start = 1; dose_cycles = 8'd2; mix_cycles = 8'd3;
    tick;
    abort = 0; start = 0;
    chk("abort_start_busy", 1, 32'(busy), 32'd0);
    chk("abort_start_sv",   1, 32'(sample_valve), 32'd0);

    // Abort mid-sequence at cycle 10.
    run_seq(2, 3, 9, -1);
    check_cycle(10, 2, 3);
    abort = 1;
    tick;
    abort = 0;
    check_cycle(0, 2, 3);
    chk("abort_state", 11, 32'(state_dbg), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check_cycle(0, 2, 3);
    end
    run_seq(1, 2, done_cycle(1, 2) + 2, -1);

    // Asynchronous reset mid-run at cycle 20.
    run_seq(2, 3, 19, -1);
    check_cycle(20, 2, 3);
    #2 rst_n = 0;
    #1;
    check_cycle(0, 2, 3);
    chk("rst_async_state", 20, 32'(state_dbg), 32'd0);
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      tick;
      check_cycle(0, 2, 3);
    end
    run_seq(3, 1, done_cycle(3, 1) + 2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
